// File: rtl/mac_vec_pkg.sv
// Shared width helpers and default sizing for the vector MAC.
package mac_vec_pkg;

  // Ceiling log2, usable in constant expressions (clog2(1) == 0).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Full-precision width of one signed lane product.
  function automatic int prod_width(input int in_w, input int wt_w);
    return in_w + wt_w;
  endfunction

  // Width of the lane sum; grows by one bit per adder-tree level.
  function automatic int sum_width(input int in_w, input int wt_w, input int lanes);
    return in_w + wt_w + clog2(lanes);
  endfunction

  localparam int DEF_LANES = 4;
  localparam int DEF_IN_W  = 8;
  localparam int DEF_WT_W  = 8;
  localparam int DEF_ACC_W = 32;

  // Derived widths for the default configuration.
  localparam int PROD_W = prod_width(DEF_IN_W, DEF_WT_W);
  localparam int SUM_W  = sum_width(DEF_IN_W, DEF_WT_W, DEF_LANES);

endpackage

// File: rtl/mac_vec_tree.sv
// Registered lane multipliers (S1) followed by a registered adder tree (S2).
// Each stage carries a valid and a last bit alongside its data.
module mac_vec_tree
  import mac_vec_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int WT_W  = DEF_WT_W,
  localparam int PROD_BITS = prod_width(IN_W, WT_W),
  localparam int SUM_BITS  = sum_width(IN_W, WT_W, LANES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       advance,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic [LANES*IN_W-1:0]      in_data,
  input  logic [LANES*WT_W-1:0]      in_weight,
  output logic                       sum_valid,
  output logic                       sum_last,
  output logic signed [SUM_BITS-1:0] sum
);

  logic signed [PROD_BITS-1:0] prod_d [LANES];
  logic signed [PROD_BITS-1:0] prod_q [LANES];
  logic signed [SUM_BITS-1:0]  sum_d;
  logic                        s1_valid;
  logic                        s1_last;

  // Sign-extend each lane to product width, then multiply; the low bits are exact.
  always_comb begin
    logic signed [PROD_BITS-1:0] a_ext;
    logic signed [PROD_BITS-1:0] b_ext;
    a_ext = '0;
    b_ext = '0;
    for (int k = 0; k < LANES; k++) begin
      a_ext     = PROD_BITS'($signed(in_data[k*IN_W +: IN_W]));
      b_ext     = PROD_BITS'($signed(in_weight[k*WT_W +: WT_W]));
      prod_d[k] = a_ext * b_ext;
    end
  end

  // Sum the registered products at full tree width.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < LANES; k++) begin
      sum_d = sum_d + SUM_BITS'(prod_q[k]);
    end
  end

  // Stage registers: flush on clear, freeze when the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
      sum       <= '0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
    end else if (clear) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      sum_valid <= 1'b0;
      sum_last  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      prod_q    <= prod_d;
      sum_valid <= s1_valid;
      sum_last  <= s1_last;
      sum       <= sum_d;
    end
  end

endmodule

// File: rtl/mac_vec.sv
// Vector multiply-accumulate: LANES signed products per beat, summed and
// accumulated across beats until the last beat, then presented on a
// valid/ready output. Optional saturation is enabled by MAC_VEC_SAT_EN.
module mac_vec
  import mac_vec_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int IN_W  = DEF_IN_W,
  parameter int WT_W  = DEF_WT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic                    in_last_i,
  input  logic [LANES*IN_W-1:0]   in_data_i,
  input  logic [LANES*WT_W-1:0]   in_weight_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] out_data_o,
  output logic                    out_sat_o
);

  localparam int SUM_BITS = sum_width(IN_W, WT_W, LANES);

  logic                       stall;
  logic                       accept;
  logic                       sum_valid;
  logic                       sum_last;
  logic signed [SUM_BITS-1:0] sum;
  logic signed [ACC_W-1:0]    sum_ext;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    acc_next;

  assign stall      = out_valid_o & ~out_ready_i;
  assign in_ready_o = ~stall & ~clear_i;
  assign accept     = in_valid_i & in_ready_o;

  mac_vec_tree #(
    .LANES (LANES),
    .IN_W  (IN_W),
    .WT_W  (WT_W)
  ) u_tree (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .advance   (~stall),
    .in_valid  (accept),
    .in_last   (in_last_i),
    .in_data   (in_data_i),
    .in_weight (in_weight_i),
    .sum_valid (sum_valid),
    .sum_last  (sum_last),
    .sum       (sum)
  );

  // Sign-extend the tree sum to accumulator width.
  always_comb begin
    sum_ext = ACC_W'(sum);
  end

`ifdef MAC_VEC_SAT_EN
  logic signed [ACC_W:0] wide;
  logic                  step_sat;
  logic                  acc_sat;
  logic                  sat_q;

  // One extra bit detects overflow; clamp to the signed range when it occurs.
  always_comb begin
    wide     = {acc[ACC_W-1], acc} + {sum_ext[ACC_W-1], sum_ext};
    step_sat = wide[ACC_W] ^ wide[ACC_W-1];
    acc_next = wide[ACC_W-1:0];
    if (step_sat) begin
      acc_next = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Sticky saturation flag per dot product, reported alongside its result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_sat <= 1'b0;
      sat_q   <= 1'b0;
    end else if (clear_i) begin
      acc_sat <= 1'b0;
      sat_q   <= 1'b0;
    end else if (!stall && sum_valid) begin
      if (sum_last) begin
        sat_q   <= acc_sat | step_sat;
        acc_sat <= 1'b0;
      end else begin
        acc_sat <= acc_sat | step_sat;
      end
    end
  end

  assign out_sat_o = sat_q;
`else
  // Plain two's-complement accumulation wraps modulo 2^ACC_W.
  always_comb begin
    acc_next = acc + sum_ext;
  end

  assign out_sat_o = 1'b0;
`endif

  // S3: accumulate non-last beats, publish on the last beat, drop valid on handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else if (clear_i) begin
      acc         <= '0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
    end else if (!stall) begin
      if (sum_valid && sum_last) begin
        out_data_o  <= acc_next;
        acc         <= '0;
        out_valid_o <= 1'b1;
      end else begin
        if (sum_valid) acc <= acc_next;
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_vec.md
MAC_VEC -- requirements
Module: mac_vec

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel signed multiply lanes (power of two, 1..16).
REQ-002 SHALL have parameter IN_W, default 8, signed input operand width.
REQ-003 SHALL have parameter WT_W, default 8, signed weight operand width.
REQ-004 SHALL have parameter ACC_W, default 32, signed accumulator/output width (>= IN_W+WT_W+log2(LANES)).
REQ-005 SHALL have port clk_i, input, 1, the one clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-007 SHALL have port clear_i, input, 1, synchronous flush of pipeline, accumulator and output.
REQ-008 SHALL have port in_valid_i, input, 1, input beat valid.
REQ-009 SHALL have port in_ready_o, output, 1, input beat accepted when high with in_valid_i.
REQ-010 SHALL have port in_last_i, input, 1, marks final beat of a dot product.
REQ-011 SHALL have port in_data_i, input, LANES*IN_W, packed signed inputs (lane 0 at LSBs).
REQ-012 SHALL have port in_weight_i, input, LANES*WT_W, packed signed weights (lane 0 at LSBs).
REQ-013 SHALL have port out_valid_o, output, 1, result valid.
REQ-014 SHALL have port out_ready_i, input, 1, result consumed when high with out_valid_o.
REQ-015 SHALL have port out_data_o, output, ACC_W, signed dot-product result.
REQ-016 SHALL have port out_sat_o, output, 1, result saturated (constant 0 without MAC_VEC_SAT_EN).

Function
REQ-017 SHALL compute out_data_o = sum over all beats up to and including the in_last_i beat of sum over lanes of in_data_i[k]*in_weight_i[k], signed.
REQ-018 SHALL pipeline: S1 registers LANES products (IN_W+WT_W bits); S2 registers adder-tree sum (IN_W+WT_W+log2(LANES) bits); S3 updates accumulator/output.
REQ-019 SHALL assert out_valid_o exactly 3 cycles after acceptance of the in_last_i beat when not stalled.
REQ-020 SHALL define stall = out_valid_o & ~out_ready_i; during stall all pipeline registers, valid bits and accumulator hold.
REQ-021 SHALL drive in_ready_o = ~stall & ~clear_i; accepts one beat per cycle otherwise.
REQ-022 SHALL carry a valid bit and last bit per stage; bubbles do not change the accumulator.
REQ-023 SHALL, on S3 valid non-last: acc <= acc + sext(sum); on S3 valid last: out_data_o <= acc + sext(sum), acc <= 0, out_valid_o <= 1.
REQ-024 SHALL clear out_valid_o on out_ready_i handshake unless a new result loads the same cycle (then out_valid_o stays 1).
REQ-025 SHALL treat a single beat with in_last_i=1 as a complete one-beat dot product.
REQ-026 SHALL, on clear_i, zero accumulator, stage valids and out_valid_o next cycle; a beat presented with clear_i is dropped.
REQ-027 SHALL, without saturation, wrap accumulation two's-complement modulo 2^ACC_W.

Reset
REQ-028 SHALL, on rst_i, asynchronously zero all stage registers, valids, accumulator, out_data_o, out_sat_o, out_valid_o; in_ready_o=1 after release.
REQ-029 SHALL discard in-flight beats and partial sums on reset mid-operation; no result emitted for them.

Configuration
REQ-030 SHALL, with MAC_VEC_SAT_EN defined, clamp every accumulation step to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and set a sticky flag reported on out_sat_o with the result, cleared on next dot product start.
REQ-031 SHALL, without MAC_VEC_SAT_EN, omit clamp logic and tie out_sat_o to 0.

Structure
REQ-032 SHALL place width-derivation constants (PROD_W, SUM_W) and clog2 helper in package mac_vec_pkg.
REQ-033 SHALL implement the registered multiply + adder tree as sub-module mac_vec_tree; accumulator, handshake and saturation stay in mac_vec.

Verification
REQ-034 SHALL test: LANES=4, one beat data {1,2,3,4} weights {5,6,7,8}, last=1 -> out_data_o=70, out_valid_o 3 cycles later.
REQ-035 SHALL test: 3 back-to-back beats all data=-128, weights=127, last on beat 3 -> out_data_o=-195072.
REQ-036 SHALL test: out_ready_i low 5 cycles with result pending and continuous input -> in_ready_o=0 those cycles, no beat lost, next result correct.
REQ-037 SHALL test: clear_i mid-vector after 2 beats, then fresh one-beat vector {1,1,1,1}x{1,1,1,1} -> out_data_o=4.
REQ-038 SHALL test: ACC_W=16, 3 beats of sum 16384 -> 49152 wraps to -16384 without macro; 32767 with out_sat_o=1 with MAC_VEC_SAT_EN.
REQ-039 SHALL test: rst_i pulsed asynchronously mid-vector -> all outputs 0 immediately, no spurious out_valid_o after release.
